// File: rtl/v_sv_src_fifo.sv
// ---------------------------------------------------------------------------
// v_sv_src_fifo
//   Source-side synchronous FIFO with a valid/ready handshake on each side.
//   Entries are written into a small register array and read back from the
//   head slot. There is no same-cycle bypass. An entry pushed at edge N first
//   appears on out_data/out_valid after edge N.
//
// Parameters
//   WIDTH     data bits per entry (default 8)
//   DEPTH     number of entries (default 4). Must be a power of two and >= 2,
//             so that the pointers wrap naturally.
//
// Ports
//   clk          sole clock; all state changes on its rising edge
//   rst          synchronous active-high reset
//   in_valid     upstream offers in_data this cycle
//   in_ready     FIFO can accept an entry (count != DEPTH)
//   in_data      upstream payload
//   out_valid    out_data holds the oldest stored entry (count != 0)
//   out_ready    downstream consumes the head this cycle
//   out_data     head entry, read from storage (never from in_data)
//   count        current occupancy, 0..DEPTH
//   full_hit     sticky flag: in_valid was seen while full; cleared by rst only
//
// Optional feature (macro V_SV_SRC_FIFO_PARITY_EN)
//   in_par       parity bit stored alongside each entry
//   out_par_err  out_valid && (^out_data != stored parity of the head)
// ---------------------------------------------------------------------------
module v_sv_src_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
`ifdef V_SV_SRC_FIFO_PARITY_EN
    input  logic                     in_par,
    output logic                     out_par_err,
`endif
    output logic                     full_hit
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Even parity of one data word.
    function automatic logic calc_par(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             full_hit_r;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             push_s;
    logic             pop_s;

    // Handshake flags are decoded from the registered occupancy only.
    always_comb begin
        in_ready_s  = (count_r != DEPTH_C);
        out_valid_s = (count_r != CNT_ZERO);
        push_s      = in_valid && in_ready_s;
        pop_s       = out_valid_s && out_ready;
    end

    // Occupancy update. A simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and the sticky full_hit flag. Reset discards the
    // stored entries and wins over any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            full_hit_r <= 1'b0;
        end else begin
            // DEPTH is a power of two, so AW-bit pointers wrap DEPTH-1 -> 0.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            if (in_valid && !in_ready_s) begin
                full_hit_r <= 1'b1;
            end
        end
    end

    // Storage array write. The array is deliberately not reset, and a push
    // in the reset cycle is not written.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

`ifdef V_SV_SRC_FIFO_PARITY_EN
    logic par_r [DEPTH];

    // Parity sideband storage, written in step with the data array.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            par_r[wr_ptr_r] <= in_par;
        end
    end

    // Head parity check, combinational from the registered head slot.
    always_comb begin
        out_par_err = out_valid_s && (calc_par(mem_r[rd_ptr_r]) != par_r[rd_ptr_r]);
    end
`endif

    // Output drive. out_data is the registered head slot.
    always_comb begin
        in_ready  = in_ready_s;
        out_valid = out_valid_s;
        out_data  = mem_r[rd_ptr_r];
        count     = count_r;
        full_hit  = full_hit_r;
    end

endmodule

// File: tb/tb_v_sv_src_fifo.sv
// ---------------------------------------------------------------------------
// tb_v_sv_src_fifo
//   Directed bench for v_sv_src_fifo (WIDTH=8, DEPTH=4). The driver pushes
//   each value it expects the FIFO to accept into a scoreboard queue. A
//   monitor on the falling edge pops from the queue and compares whenever a
//   pop handshake is about to happen. Status outputs are checked directly
//   against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_v_sv_src_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       full_hit;
`ifdef V_SV_SRC_FIFO_PARITY_EN
    logic       in_par = 1'b0;
    logic       out_par_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    v_sv_src_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
`ifdef V_SV_SRC_FIFO_PARITY_EN
        .in_par    (in_par),
        .out_par_err(out_par_err),
`endif
        .full_hit  (full_hit)
    );

    always #5 clk = ~clk;

    // Monitor: the pop handshake takes effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL unexpected_out: got %h, queue empty", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err = n_err + 1;
                    $display("FAIL out_data: got %h, expected %h", out_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_val(input logic [7:0] v, input bit expect_it);
        in_valid = 1'b1;
        in_data  = v;
        if (expect_it) exp_q.push_back(v);
        tick();
        in_valid = 1'b0;
    endtask

    // Drain with out_ready=1 under a cycle budget.
    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && count != 3'd0; i++) tick();
        tick();
        out_ready = 1'b0;
        check("drain_empty", 32'(count), 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_full_hit", 32'(full_hit), 32'd0);

        // Three pushes, no pops
        push_val(8'h11, 1'b1);
        push_val(8'h22, 1'b1);
        push_val(8'h33, 1'b1);
        check("p3_count", 32'(count), 32'd3);
        check("p3_head", 32'(out_data), 32'h11);
        check("p3_in_ready", 32'(in_ready), 32'd1);
        check("p3_full_hit", 32'(full_hit), 32'd0);
        drain();

        // Fill, then offer 0xFF while full
        push_val(8'hA0, 1'b1);
        push_val(8'hA1, 1'b1);
        push_val(8'hA2, 1'b1);
        push_val(8'hA3, 1'b1);
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        check("full_hit_set", 32'(full_hit), 32'd1);
        check("full_count_hold", 32'(count), 32'd4);
        // Pop while full with in_valid still high: the pop happens, the push does not
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("full_pop_count", 32'(count), 32'd3);
        check("full_pop_in_ready", 32'(in_ready), 32'd1);
        check("full_pop_head", 32'(out_data), 32'hA1);
        drain();
        check("full_hit_sticky", 32'(full_hit), 32'd1);

        // Simultaneous push/pop with one entry held, pointers wrap
        push_val(8'h54, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h55 + 8'(i);
            exp_q.push_back(8'h55 + 8'(i));
            tick();
            check("pp_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("pp_head", 32'(out_data), 32'h5E);
        drain();

        // No pass-through when empty
        in_valid  = 1'b1;
        in_data   = 8'h7E;
        out_ready = 1'b1;
        exp_q.push_back(8'h7E);
        check("bypass_out_valid0", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("bypass_out_valid1", 32'(out_valid), 32'd1);
        check("bypass_out_data", 32'(out_data), 32'h7E);
        tick();
        out_ready = 1'b0;
        check("bypass_empty", 32'(count), 32'd0);

        // Reset mid-operation discards contents and ignores the push
        push_val(8'hC1, 1'b0);
        push_val(8'hC2, 1'b0);
        push_val(8'hC3, 1'b0);
        check("pre_rst_count", 32'(count), 32'd3);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_full_hit", 32'(full_hit), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        push_val(8'h42, 1'b1);
        check("post_rst_head", 32'(out_data), 32'h42);
        drain();

`ifdef V_SV_SRC_FIFO_PARITY_EN
        // Parity: 0x03 has even parity 0
        in_par = 1'b1;
        push_val(8'h03, 1'b1);
        check("par_err_set", 32'(out_par_err), 32'd1);
        in_par = 1'b0;
        drain();
        push_val(8'h03, 1'b1);
        check("par_err_clr", 32'(out_par_err), 32'd0);
        drain();
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/v_sv_src_fifo.md
V_SV_SRC_FIFO -- requirements
Module: v_sv_src_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data bits per entry.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 in_valid  input  1  upstream offers in_data this cycle.
REQ-006 in_ready  output  1  FIFO can accept an entry this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 out_valid  output  1  out_data holds the oldest stored entry.
REQ-009 out_ready  input  1  downstream stage (v_sv_mod side) consumes this cycle.
REQ-010 out_data  output  WIDTH  head entry; registered, not a combinational bypass of in_data.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 full_hit  output  1  sticky flag: in_valid seen while full.

Function
REQ-013 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-014 in_ready SHALL equal (count != DEPTH), decoded from registered state only.
REQ-015 out_valid SHALL equal (count != 0); out_data SHALL be stable while out_valid && !out_ready.
REQ-016 Latency: an entry pushed at edge N SHALL be visible on out_data/out_valid after edge N; no same-cycle pass-through when empty.
REQ-017 Ordering SHALL be strictly first-in first-out.
REQ-018 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without gap.
REQ-019 count next = count + push - pop; push and pop in the same cycle SHALL leave count unchanged and both SHALL take effect.
REQ-020 When full, in_ready=0, so no push occurs even if a pop happens in the same cycle; in_ready rises the cycle after the pop.
REQ-021 When empty, no pop occurs regardless of out_ready.
REQ-022 full_hit SHALL set on any cycle with in_valid && !in_ready and SHALL remain set until rst.
REQ-023 Data in unoccupied entries is don't-care; out_data is don't-care when out_valid=0.

Reset
REQ-024 With rst high at a clock edge: pointers=0, count=0, full_hit=0, in_ready=1 and out_valid=0 from the next cycle.
REQ-025 Reset mid-operation SHALL discard all stored entries; a push or pop in the reset cycle SHALL be ignored.
REQ-026 Storage array contents are not reset.

Configuration
REQ-027 Macro V_SV_SRC_FIFO_PARITY_EN enables per-entry parity checking.
REQ-028 When defined: extra ports in_par (input, 1) and out_par_err (output, 1); in_par is stored with each entry; out_par_err SHALL equal out_valid && (^out_data != stored parity of the head), combinational from registered state.
REQ-029 When undefined: neither port exists; no parity storage; all other behaviour is identical.

Verification
REQ-030 Reset, then push 0x11,0x22,0x33 on consecutive cycles with out_ready=0 -> count=3, out_data=0x11, in_ready=1, full_hit=0.
REQ-031 Fill DEPTH=4 entries (0xA0..0xA3), hold in_valid=1 with 0xFF -> in_ready=0, full_hit=1 and sticky; then drain -> outputs 0xA0,0xA1,0xA2,0xA3 and 0xFF is never output.
REQ-032 One entry stored, push 0x55 and pop in the same cycle, repeated for 10 cycles -> count stays 1 and pointers wrap; output order matches input order.
REQ-033 Empty FIFO, push 0x7E with out_ready=1 -> out_valid=0 in the push cycle, out_valid=1 with out_data=0x7E the next cycle.
REQ-034 Three entries stored, assert rst for one cycle alongside in_valid -> count=0, out_valid=0, full_hit=0 afterwards; the earlier entries never appear.
REQ-035 With V_SV_SRC_FIFO_PARITY_EN defined, push 0x03 with in_par=1 (wrong) -> out_par_err=1 while that entry is at the head; push 0x03 with in_par=0 -> out_par_err=0.
